// File: rtl/counter_seq_ctrl.sv
// Run/pause/clear BCD up-counter (0000-9999) with a multiplexed 4-digit scan output.
// Optional leading-zero blanking of the scanned digit is enabled by defining LEADING_ZERO_BLANK_EN.
module counter_seq_ctrl #(
  parameter int TICK_DIV = 2500000,
  parameter int SCAN_DIV = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_sel,
  output logic [3:0]  digit_bcd,
  output logic        blank,
  output logic [1:0]  state,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t          state_r;
  state_t          state_nxt;
  logic [PW-1:0]   presc_r;
  logic [SW-1:0]   scan_r;
  logic            tick;

  // Ripple-carry increment of a four-digit BCD value; 9999 rolls to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick  = (state_r == RUN) && (presc_r == PW'(TICK_DIV - 1));
  assign state = state_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; clear beats everything, stop wins only while running
  always_comb begin
    state_nxt = state_r;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (start) state_nxt = RUN;   else state_nxt = IDLE;
        RUN:     if (stop)  state_nxt = PAUSE; else state_nxt = RUN;
        PAUSE:   if (start) state_nxt = RUN;   else state_nxt = PAUSE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prescaler, BCD count and rollover pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      bcd_out <= 16'h0000;
      wrap    <= 1'b0;
    end else if (clear) begin
      presc_r <= '0;
      bcd_out <= 16'h0000;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state_r == RUN) begin
        if (tick) begin
          presc_r <= '0;
          bcd_out <= bcd_inc(bcd_out);
          wrap    <= (bcd_out == 16'h9999);
        end else begin
          presc_r <= presc_r + PW'(1);
        end
      end else if (state_r != PAUSE) begin
        presc_r <= '0;
      end
    end
  end

  // Digit scan: free-running in every state, rotates the one-hot select
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r    <= '0;
      digit_sel <= 4'b0001;
    end else if (scan_r == SW'(SCAN_DIV - 1)) begin
      scan_r    <= '0;
      digit_sel <= {digit_sel[2:0], digit_sel[3]};
    end else begin
      scan_r    <= scan_r + SW'(1);
    end
  end

  // Selected digit mux
  always_comb begin
    digit_bcd = 4'd0;
    case (digit_sel)
      4'b0001: digit_bcd = bcd_out[3:0];
      4'b0010: digit_bcd = bcd_out[7:4];
      4'b0100: digit_bcd = bcd_out[11:8];
      4'b1000: digit_bcd = bcd_out[15:12];
      default: digit_bcd = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; units never blanks
  always_comb begin
    blank = 1'b0;
    case (digit_sel)
      4'b0010: blank = (bcd_out[15:4]  == 12'd0);
      4'b0100: blank = (bcd_out[15:8]  == 8'd0);
      4'b1000: blank = (bcd_out[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized and directed bench for counter_seq_ctrl (TICK_DIV=4, SCAN_DIV=2) against a decimal reference model.
// Define LEADING_ZERO_BLANK_EN for both files to check the blanking build.
module tb_counter_seq_ctrl;

  localparam int TD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_sel;
  logic [3:0]  digit_bcd;
  logic        blank;
  logic [1:0]  state;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: plain decimal count, 0=idle 1=run 2=pause, digit index 0..3
  int m_st = 0, m_n = 0, m_pre = 0, m_wr = 0, m_idx = 0, m_scan = 0;
  int wrap_seen = 0;
  int p10[4] = '{1, 10, 100, 1000};

  counter_seq_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .digit_bcd(digit_bcd),
    .blank(blank), .state(state), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return 16'((n / 1000) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  // One clock: apply inputs, advance the model, compare every output after the edge
  task automatic step(input logic s, input logic p, input logic c, input logic r);
    bit tk;
    bit exp_blank;
    start = s; stop = p; clear = c; rst = r;
    @(posedge clk);
    if (r) begin
      m_st = 0; m_n = 0; m_pre = 0; m_wr = 0; m_idx = 0; m_scan = 0;
    end else begin
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_scan++;
      end
      tk   = (m_st == 1) && (m_pre == TD - 1);
      m_wr = 0;
      if (c) begin
        m_st = 0; m_n = 0; m_pre = 0;
      end else begin
        if (m_st == 1) begin
          if (tk) begin
            m_pre = 0;
            if (m_n == 9999) begin m_n = 0; m_wr = 1; end
            else m_n++;
          end else begin
            m_pre++;
          end
        end
        if (m_st == 0 && s) m_st = 1;
        else if (m_st == 1 && p) m_st = 2;
        else if (m_st == 2 && s) m_st = 1;
      end
    end
    #1;
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = (m_idx > 0) && (m_n < p10[m_idx]);
`else
    exp_blank = 1'b0;
`endif
    if (wrap === 1'b1) wrap_seen++;
    check_value("state",     {14'd0, state},     16'(m_st));
    check_value("bcd_out",   bcd_out,            to_bcd(m_n));
    check_value("wrap",      {15'd0, wrap},      16'(m_wr));
    check_value("digit_sel", {12'd0, digit_sel}, 16'(1 << m_idx));
    check_value("digit_bcd", {12'd0, digit_bcd}, 16'((m_n / p10[m_idx]) % 10));
    check_value("blank",     {15'd0, blank},     {15'd0, exp_blank});
  endtask

  initial begin
    int k;
    // Reset
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_value("reset_sel", {12'd0, digit_sel}, 16'h0001);

    // Stay idle until start, then one-cycle start and 40 cycles of run
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("idle_hold", {14'd0, state}, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("run40_bcd", bcd_out, 16'h0010);
    check_value("run40_state", {14'd0, state}, 16'h0001);

    // Pause 20 cycles then resume
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_value("paused", {14'd0, state}, 16'h0002);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("pause_frozen", bcd_out, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random control traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
           1'($urandom_range(49) == 0), 1'($urandom_range(499) == 0));

    // Clear coincident with start and a tick
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 20 && !(m_st == 1 && m_pre == TD - 1 && m_n > 0); k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_value("clr_tick_state", {14'd0, state}, 16'h0000);
    check_value("clr_tick_bcd", bcd_out, 16'h0000);
    check_value("clr_tick_wrap", {15'd0, wrap}, 16'h0000);

    // Count to 0042 and watch the scan
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 400 && m_n < 42; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_value("reach_0042", bcd_out, 16'h0042);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run at 1234
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 6000 && m_n < 1234; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("reach_1234", bcd_out, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_value("rst_run_state", {14'd0, state}, 16'h0000);
    check_value("rst_run_bcd", bcd_out, 16'h0000);
    check_value("rst_run_sel", {12'd0, digit_sel}, 16'h0001);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("rst_idle_hold", {14'd0, state}, 16'h0000);

    // Full rollover 9999 -> 0000
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 41000 && m_n < 9998; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("reach_9998", bcd_out, 16'h9998);
    wrap_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_value("wrap_count", 16'(wrap_seen), 16'd1);
    check_value("wrap_state", {14'd0, state}, 16'h0001);
    check_value("wrap_bcd_low", {8'd0, bcd_out[15:8]}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
